// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared op encodings, FSM state type and sizing for muldiv_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

    localparam int XLEN         = 32;
    localparam int ITER_DEFAULT = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_seq_if.sv
// ============================================================================
// Module      : muldiv_seq_if
// Description : CPU-side bus of the sequential multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface muldiv_seq_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall;
    logic        done;
    logic        dz;

    modport master (
        output start, op, rs_val, rt_val, hi_we, lo_we,
        input  hi, lo, stall, done, dz
    );

    modport slave (
        input  start, op, rs_val, rt_val, hi_we, lo_we,
        output hi, lo, stall, done, dz
    );
endinterface

`default_nettype wire

// File: rtl/muldiv_iter.sv
// ============================================================================
// Module      : muldiv_iter
// Description : One step of shift-add multiply or restoring divide.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_iter #(
    parameter int W = 32
) (
    input  logic           is_div,
    input  logic [2*W-1:0] acc,
    input  logic [W-1:0]   operand,
    output logic [2*W-1:0] acc_next
);

    logic [W:0]   sum;
    logic         ge;
    logic [W-1:0] rem_new;

    // Divide: acc = {remainder, unshifted dividend bits / quotient bits}.
    // The shifted remainder is W+1 bits; the low W bits of the difference are
    // exact because the restored remainder is always below the divisor.
    always_comb begin
        sum      = {1'b0, acc[2*W-1:W]} + {1'b0, operand};
        ge       = acc[2*W-1:W-1] >= {1'b0, operand};
        rem_new  = ge ? (acc[2*W-2:W-1] - operand) : acc[2*W-2:W-1];
        acc_next = acc;
        if (is_div) begin
            acc_next = {rem_new, acc[W-2:0], ge};
        end else if (acc[0]) begin
            acc_next = {sum, acc[W-1:1]};
        end else begin
            acc_next = {1'b0, acc[2*W-1:1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_seq.sv
// ============================================================================
// Module      : muldiv_seq
// Description : Sequential MIPS mult/multu/div/divu unit with HI/LO registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int ITER = ITER_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_seq_if.slave   bus
);

    localparam int CNT_W = $clog2(ITER + 1);

    state_t              state;
    logic [1:0]          op_reg;
    logic [XLEN-1:0]     operand;
    logic [2*XLEN-1:0]   acc;
    logic [2*XLEN-1:0]   acc_next;
    logic                neg_res;
    logic                neg_rem;
    logic                div_zero;
    logic [CNT_W-1:0]    count;
    logic [XLEN-1:0]     hi_reg;
    logic [XLEN-1:0]     lo_reg;
    logic                done_reg;
    logic                dz_reg;

    logic                in_div;
    logic                sign_a;
    logic                sign_b;
    logic [XLEN-1:0]     mag_a;
    logic [XLEN-1:0]     mag_b;
    logic                reg_is_div;
    logic [2*XLEN-1:0]   result;

    always_comb begin
        in_div     = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
        sign_a     = ((bus.op == OP_MULT) || (bus.op == OP_DIV)) && bus.rs_val[XLEN-1];
        sign_b     = ((bus.op == OP_MULT) || (bus.op == OP_DIV)) && bus.rt_val[XLEN-1];
        mag_a      = magnitude(bus.rs_val, sign_a);
        mag_b      = magnitude(bus.rt_val, sign_b);
        reg_is_div = !((op_reg == OP_MULT) || (op_reg == OP_MULTU));
    end

    muldiv_iter #(.W(XLEN)) u_iter (
        .is_div   (reg_is_div),
        .acc      (acc),
        .operand  (operand),
        .acc_next (acc_next)
    );

    // Sign flags are zero for unsigned ops and for divide-by-zero, so the raw
    // accumulator passes straight through in those cases.
    always_comb begin
        result = acc;
        if (reg_is_div) begin
            result[XLEN-1:0]      = neg_res ? -acc[XLEN-1:0]      : acc[XLEN-1:0];
            result[2*XLEN-1:XLEN] = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        end else if (neg_res) begin
            result = -acc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            op_reg   <= '0;
            operand  <= '0;
            acc      <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            count    <= '0;
            hi_reg   <= '0;
            lo_reg   <= '0;
            done_reg <= 1'b0;
            dz_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        op_reg <= bus.op;
                        count  <= '0;
                        if (in_div && (bus.rt_val == '0)) begin
                            operand  <= '0;
                            acc      <= {bus.rs_val, {XLEN{1'b1}}};
                            neg_res  <= 1'b0;
                            neg_rem  <= 1'b0;
                            div_zero <= 1'b1;
                            state    <= S_FIX;
                        end else begin
                            operand  <= in_div ? mag_b : mag_a;
                            acc      <= {{XLEN{1'b0}}, (in_div ? mag_a : mag_b)};
                            neg_res  <= sign_a ^ sign_b;
                            neg_rem  <= in_div && sign_a;
                            div_zero <= 1'b0;
                            state    <= S_CALC;
                        end
                    end else begin
                        if (bus.hi_we) hi_reg <= bus.rs_val;
                        if (bus.lo_we) lo_reg <= bus.rs_val;
                    end
                end
                S_CALC: begin
                    acc   <= acc_next;
                    count <= count + 1'b1;
                    if (count == CNT_W'(ITER - 1)) state <= S_FIX;
                end
                S_FIX: begin
                    hi_reg   <= result[2*XLEN-1:XLEN];
                    lo_reg   <= result[XLEN-1:0];
                    done_reg <= 1'b1;
                    if (reg_is_div) dz_reg <= div_zero;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.hi    = hi_reg;
    assign bus.lo    = lo_reg;
    assign bus.done  = done_reg;
    assign bus.dz    = dz_reg;
    assign bus.stall = ((state == S_IDLE) && bus.start) || (state == S_CALC) || (state == S_FIX);

endmodule

`default_nettype wire
